mdma_job_splitter: RTL

- Sits directly upstream of axi_mdma. Accepts one large copy job (src, dst, byte count).
- Splits the job into chunks of at most MAX_CHUNK bytes that never cross a MAX_CHUNK-aligned destination boundary, and issues them on the axi_mdma cmd_* channel.
- Collects the matching rpt_* reports, keeps a bounded number of chunks in flight, and returns one aggregated completion per job.

---
 rtl/mdma_split_pkg.sv | 27 ++
 rtl/mdma_split_cmd_fifo.sv | 56 +++++
 rtl/mdma_job_splitter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mdma_split_pkg.sv
// Shared types and helpers for the mdma job splitter: FSM state encoding,
// axi_mdma report status codes and the chunk-size calculation.
package mdma_split_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] MDMA_ST_OKAY     = 2'd0;
  localparam logic [1:0] MDMA_ST_MISMATCH = 2'd1;
  localparam logic [1:0] MDMA_ST_SLVERR   = 2'd2;
  localparam logic [1:0] MDMA_ST_DECERR   = 2'd3;

  // Largest chunk that fits in the remaining job and stops at the next
  // max_chunk-aligned destination boundary. max_chunk must be a power of two.
  function automatic logic [31:0] chunk_size(input logic [31:0] remaining,
                                             input logic [31:0] dst_addr,
                                             input logic [31:0] max_chunk);
    logic [31:0] room;
    room = max_chunk - (dst_addr & (max_chunk - 32'd1));
    return (remaining < room) ? remaining : room;
  endfunction

endpackage

// File: rtl/mdma_split_cmd_fifo.sv
// In-order FIFO of issued chunk commands, used to cross-check returning
// axi_mdma reports. Only instantiated when MDMA_SPLIT_RPT_CHECK_EN is defined.
module mdma_split_cmd_fifo #(
  parameter int WIDTH = 80,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int               PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST      = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign empty    = (count == '0);
  assign full     = (count == DEPTH_CNT);
  assign pop_data = mem[rd_ptr];

  // Entry storage; contents are only meaningful between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Read/write pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mdma_job_splitter.sv
// Splits one large copy job into boundary-aligned chunks for axi_mdma, keeps
// up to MAX_OUTSTANDING chunks in flight and returns one aggregated completion.
// Optional: define MDMA_SPLIT_RPT_CHECK_EN to cross-check every report against
// the command it answers (mismatch reported as MDMA_ST_MISMATCH).
module mdma_job_splitter
  import mdma_split_pkg::*;
#(
  parameter int ADDR_BITS       = 32,
  parameter int LENGTH_BITS     = 16,
  parameter int JOB_LENGTH_BITS = 24,
  parameter int MAX_CHUNK       = 4096,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [ADDR_BITS-1:0]       job_src_addr,
  input  logic [ADDR_BITS-1:0]       job_dst_addr,
  input  logic [JOB_LENGTH_BITS-1:0] job_bytes,
  input  logic                       job_valid,
  output logic                       job_ready,
  output logic [JOB_LENGTH_BITS-1:0] done_bytes,
  output logic [1:0]                 done_status,
  output logic                       done_valid,
  input  logic                       done_ready,
  output logic [ADDR_BITS-1:0]       cmd_src_addr,
  output logic [ADDR_BITS-1:0]       cmd_dst_addr,
  output logic [LENGTH_BITS-1:0]     cmd_bytes,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  input  logic [ADDR_BITS-1:0]       rpt_src_addr,
  input  logic [ADDR_BITS-1:0]       rpt_dst_addr,
  input  logic [LENGTH_BITS-1:0]     rpt_bytes,
  input  logic [1:0]                 rpt_status,
  input  logic                       rpt_valid,
  output logic                       rpt_ready,
  output logic                       busy
);

  localparam int               OUT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

  state_t                     state;
  state_t                     state_next;
  logic [ADDR_BITS-1:0]       src;
  logic [ADDR_BITS-1:0]       dst;
  logic [JOB_LENGTH_BITS-1:0] remaining;
  logic [JOB_LENGTH_BITS-1:0] rem_after;
  logic [OUT_W-1:0]           outstanding;
  logic [OUT_W-1:0]           outstanding_next;
  logic [31:0]                chunk;
  logic                       job_fire;
  logic                       cmd_fire;
  logic                       rpt_fire;
  logic                       err_next;
  logic [1:0]                 rpt_code;

  // The next chunk is always derived from the live src/dst/remaining, so the
  // payload is stable while unacknowledged and zero out of reset.
  assign chunk        = chunk_size(32'(remaining), 32'(dst), 32'(MAX_CHUNK));
  assign cmd_src_addr = src;
  assign cmd_dst_addr = dst;
  assign cmd_bytes    = LENGTH_BITS'(chunk);
  assign cmd_valid    = (state == ISSUE) && (remaining != '0) &&
                        (outstanding < OUT_MAX) && (done_status == MDMA_ST_OKAY);

  assign job_ready  = (state == IDLE);
  assign done_valid = (state == DONE);
  assign busy       = (state != IDLE);
  assign rpt_ready  = 1'b1;

  assign job_fire  = job_valid && job_ready;
  assign cmd_fire  = cmd_valid && cmd_ready;
  // Reports with nothing outstanding (e.g. stragglers after a reset) are dropped.
  assign rpt_fire  = rpt_valid && (outstanding != '0);
  assign rem_after = cmd_fire ? (remaining - JOB_LENGTH_BITS'(chunk)) : remaining;
  assign err_next  = (done_status != MDMA_ST_OKAY) ||
                     (rpt_fire && (rpt_code != MDMA_ST_OKAY));

`ifdef MDMA_SPLIT_RPT_CHECK_EN
  localparam int ENTRY_W = 2 * ADDR_BITS + LENGTH_BITS;

  logic [ENTRY_W-1:0] exp_entry;
  logic               mismatch;
  logic               unused_fifo_empty;
  logic               unused_fifo_full;

  mdma_split_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_cmd_fifo (
    .clk       (aclk),
    .rst_n     (aresetn),
    .push      (cmd_fire),
    .push_data ({cmd_src_addr, cmd_dst_addr, cmd_bytes}),
    .pop       (rpt_fire),
    .pop_data  (exp_entry),
    .empty     (unused_fifo_empty),
    .full      (unused_fifo_full)
  );

  // A report that does not echo its command is a protocol error in its own right.
  assign mismatch = (exp_entry != {rpt_src_addr, rpt_dst_addr, rpt_bytes});
  assign rpt_code = mismatch ? MDMA_ST_MISMATCH : rpt_status;
`else
  logic unused_rpt_addr;

  assign unused_rpt_addr = ^{rpt_src_addr, rpt_dst_addr};
  assign rpt_code        = rpt_status;
`endif

  // Net change of in-flight commands; a simultaneous issue and report cancel out.
  always_comb begin
    outstanding_next = outstanding;
    case ({cmd_fire, rpt_fire})
      2'b10:   outstanding_next = outstanding + 1'b1;
      2'b01:   outstanding_next = outstanding - 1'b1;
      default: outstanding_next = outstanding;
    endcase
  end

  // FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_next;
  end

  // FSM next-state: stop issuing once the job is exhausted or an error is seen,
  // then wait for every outstanding report before completing.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (job_fire) state_next = (job_bytes == '0) ? DONE : ISSUE;
      ISSUE:   if ((rem_after == '0) || err_next) state_next = DRAIN;
      DRAIN:   if (outstanding_next == '0) state_next = DONE;
      DONE:    if (done_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Job cursor: captured on accept, advanced by one chunk per command handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      src         <= '0;
      dst         <= '0;
      remaining   <= '0;
      outstanding <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (job_fire) begin
        src       <= job_src_addr;
        dst       <= job_dst_addr;
        remaining <= job_bytes;
      end else if (cmd_fire) begin
        src       <= src + ADDR_BITS'(chunk);
        dst       <= dst + ADDR_BITS'(chunk);
        remaining <= rem_after;
      end
    end
  end

  // Completion accumulation: OKAY bytes summed, first error status kept.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      done_bytes  <= '0;
      done_status <= MDMA_ST_OKAY;
    end else if (job_fire) begin
      done_bytes  <= '0;
      done_status <= MDMA_ST_OKAY;
    end else if (rpt_fire) begin
      if (rpt_code == MDMA_ST_OKAY)
        done_bytes <= done_bytes + JOB_LENGTH_BITS'(rpt_bytes);
      else if (done_status == MDMA_ST_OKAY)
        done_status <= rpt_code;
    end
  end

endmodule
